// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one operand bit per clock, MSB first.
// Define BIN2BCD_SIGNED_EN to treat bin as two's complement and convert its magnitude.
module bin2bcd_seq #(
   parameter int BIN_WIDTH = 12,
   parameter int DIGITS    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_WIDTH-1:0]  bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow,
   output logic                  sign
);

   localparam int CNT_W   = $clog2(BIN_WIDTH + 1);
   localparam int ACC_W   = 4 * DIGITS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t               state_reg, state_next;
   logic [ACC_W-1:0]     acc_reg, acc_next;
   logic [BIN_WIDTH-1:0] opnd_reg, opnd_next;
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   logic                 ovf_reg, ovf_next;
   logic                 sgn_reg, sgn_next;
   logic [ACC_W-1:0]     bcd_reg, bcd_next;
   logic                 overflow_reg, overflow_next;
   logic                 sign_reg, sign_next;

   logic [ACC_W-1:0]     acc_adj;
   logic [ACC_W-1:0]     acc_shift;
   logic                 carry_out;
   logic [BIN_WIDTH-1:0] mag;
   logic                 sgn_in;

   // Operand conditioning: the magnitude is taken as unsigned so that the most
   // negative value converts correctly.
`ifdef BIN2BCD_SIGNED_EN
   assign sgn_in = bin[BIN_WIDTH-1];
   assign mag    = bin[BIN_WIDTH-1] ? (~bin + {{(BIN_WIDTH-1){1'b0}}, 1'b1}) : bin;
`else
   assign sgn_in = 1'b0;
   assign mag    = bin;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                     (acc_reg[4*gi +: 4] + 4'd3) : acc_reg[4*gi +: 4];
      end
   endgenerate

   // A one leaving the top digit means the value no longer fits in DIGITS digits.
   assign carry_out = acc_adj[ACC_W-1];
   assign acc_shift = {acc_adj[ACC_W-2:0], opnd_reg[BIN_WIDTH-1]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         acc_reg      <= '0;
         opnd_reg     <= '0;
         cnt_reg      <= '0;
         ovf_reg      <= 1'b0;
         sgn_reg      <= 1'b0;
         bcd_reg      <= '0;
         overflow_reg <= 1'b0;
         sign_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         acc_reg      <= acc_next;
         opnd_reg     <= opnd_next;
         cnt_reg      <= cnt_next;
         ovf_reg      <= ovf_next;
         sgn_reg      <= sgn_next;
         bcd_reg      <= bcd_next;
         overflow_reg <= overflow_next;
         sign_reg     <= sign_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      acc_next      = acc_reg;
      opnd_next     = opnd_reg;
      cnt_next      = cnt_reg;
      ovf_next      = ovf_reg;
      sgn_next      = sgn_reg;
      bcd_next      = bcd_reg;
      overflow_next = overflow_reg;
      sign_next     = sign_reg;
      busy          = 1'b0;
      done          = 1'b0;

      case (state_reg)
         S_IDLE, S_DONE: begin
            done = (state_reg == S_DONE);
            if (start) begin
               acc_next   = '0;
               opnd_next  = mag;
               cnt_next   = CNT_W'(BIN_WIDTH);
               ovf_next   = 1'b0;
               sgn_next   = sgn_in;
               state_next = S_SHIFT;
            end else begin
               state_next = S_IDLE;
            end
         end
         S_SHIFT: begin
            busy      = 1'b1;
            acc_next  = acc_shift;
            opnd_next = {opnd_reg[BIN_WIDTH-2:0], 1'b0};
            ovf_next  = ovf_reg | carry_out;
            cnt_next  = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               state_next    = S_DONE;
               bcd_next      = acc_shift;
               overflow_next = ovf_reg | carry_out;
               sign_next     = sgn_reg;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign bcd      = bcd_reg;
   assign overflow = overflow_reg;
   assign sign     = sign_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed-vector bench for bin2bcd_seq; a DIGITS=3 instance shares the stimulus
// to exercise overflow truncation.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [11:0] bin;
   logic        busy, done, overflow, sign;
   logic [15:0] bcd;
   logic        busy3, done3, overflow3, sign3;
   logic [11:0] bcd3;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   bin2bcd_seq #(.BIN_WIDTH(12), .DIGITS(4)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bin      (bin),
      .busy     (busy),
      .done     (done),
      .bcd      (bcd),
      .overflow (overflow),
      .sign     (sign)
   );

   bin2bcd_seq #(.BIN_WIDTH(12), .DIGITS(3)) u_dut3 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bin      (bin),
      .busy     (busy3),
      .done     (done3),
      .bcd      (bcd3),
      .overflow (overflow3),
      .sign     (sign3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One conversion with a stray start pulse and an operand change mid-SHIFT.
   task automatic run_conv(input string tag, input logic [11:0] b, input logic [15:0] exp_bcd,
                           input logic exp_ovf, input logic exp_sign);
      int n;
      int busy_n;
      @(negedge clk);
      bin   = b;
      start = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      bin    = ~b;
      n      = 0;
      busy_n = 0;
      while (!done && n < 40) begin
         if (busy) busy_n++;
         if (n == 4) start = 1'b1;
         if (n == 5) start = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      chk({tag, ".latency"}, n, 12);
      chk({tag, ".busy_cycles"}, busy_n, 12);
      chk({tag, ".busy_at_done"}, {31'd0, busy}, 0);
      chk({tag, ".bcd"}, {16'd0, bcd}, {16'd0, exp_bcd});
      chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
      chk({tag, ".sign"}, {31'd0, sign}, {31'd0, exp_sign});
      $display("conv %s: bin=0x%03h bcd=0x%04h ovf=%b sign=%b latency=%0d", tag, b, bcd, overflow, sign, n);
      @(posedge clk); #1;
      chk({tag, ".done_pulse"}, {31'd0, done}, 0);
   endtask

   initial begin
      int n;
      int m;
      int seen;
      rst_n = 1'b0;
      start = 1'b0;
      bin   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.busy", {31'd0, busy}, 0);
      chk("reset.done", {31'd0, done}, 0);
      chk("reset.bcd", {16'd0, bcd}, 0);
      chk("reset.overflow", {31'd0, overflow}, 0);
      chk("reset.sign", {31'd0, sign}, 0);
      $display("reset: busy=%b done=%b bcd=0x%04h", busy, done, bcd);
      rst_n = 1'b1;

`ifdef BIN2BCD_SIGNED_EN
      run_conv("min_neg", 12'h800, 16'h2048, 1'b0, 1'b1);
      run_conv("minus_one", 12'hFFF, 16'h0001, 1'b0, 1'b1);
      run_conv("minus_999", 12'hC19, 16'h0999, 1'b0, 1'b1);
`else
      run_conv("max_unsigned", 12'd4095, 16'h4095, 1'b0, 1'b0);
      chk("d3.max.bcd", {20'd0, bcd3}, 32'h095);
      chk("d3.max.overflow", {31'd0, overflow3}, 1);
`endif
      run_conv("zero", 12'd0, 16'h0000, 1'b0, 1'b0);
      run_conv("nines", 12'd999, 16'h0999, 1'b0, 1'b0);
      run_conv("d3_ovf", 12'd1234, 16'h1234, 1'b0, 1'b0);
      chk("d3.1234.bcd", {20'd0, bcd3}, 32'h234);
      chk("d3.1234.overflow", {31'd0, overflow3}, 1);
      run_conv("d3_fit", 12'd999, 16'h0999, 1'b0, 1'b0);
      chk("d3.999.overflow", {31'd0, overflow3}, 0);

      // Back-to-back: start held high across two conversions.
      @(negedge clk);
      bin   = 12'd10;
      start = 1'b1;
      @(posedge clk); #1;
      bin = 12'd255;
      n   = 0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b2b.first_latency", n, 12);
      chk("b2b.first_bcd", {16'd0, bcd}, 32'h0010);
      $display("conv b2b_first: bcd=0x%04h latency=%0d", bcd, n);
      m = 0;
      @(posedge clk); #1;
      m++;
      while (!done && m < 40) begin
         @(posedge clk); #1;
         m++;
      end
      start = 1'b0;
      chk("b2b.spacing", m, 13);
      chk("b2b.second_bcd", {16'd0, bcd}, 32'h0255);
      $display("conv b2b_second: bcd=0x%04h spacing=%0d", bcd, m);
      @(posedge clk); #1;
      chk("b2b.idle_busy", {31'd0, busy}, 0);
      chk("b2b.idle_done", {31'd0, done}, 0);

      // Reset at shift cycle 5 aborts the conversion.
      @(negedge clk);
      bin   = 12'd500;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("abort.busy_before", {31'd0, busy}, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort.busy", {31'd0, busy}, 0);
      chk("abort.done", {31'd0, done}, 0);
      chk("abort.bcd", {16'd0, bcd}, 0);
      chk("abort.overflow", {31'd0, overflow}, 0);
      chk("abort.sign", {31'd0, sign}, 0);
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done || busy) seen = 1;
      end
      chk("abort.no_done", seen, 0);
      $display("abort: bcd=0x%04h busy=%b done=%b", bcd, busy, done);

      // Reset wins over start on the same edge.
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b1;
      bin   = 12'd5;
      @(posedge clk); #1;
      chk("rst_prio.busy", {31'd0, busy}, 0);
      $display("rst_prio: busy=%b", busy);
      rst_n = 1'b1;
      start = 1'b0;

      run_conv("after_abort", 12'd77, 16'h0077, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
